dense_layer_sequencer: RTL and testbench

Sequences the fully connected output stage of the 2-D convolution network: 128 flattened conv features by 10 output neurons, on one shared multiply-accumulate unit. It sits between the conv feature buffer and the classifier output. For each neuron it drives the feature-buffer and weight-ROM read addresses and accumulates 128 products. It then adds the neuron bias and streams the 10 scores out over a valid/ready handshake. The weight and bias ROMs are external and are loaded from the `data6_3` package: 6-bit signed `dlWeights[0:1279]` and `dlBiases[9:0]`.

---
 rtl/dense_layer_sequencer.sv | 162 ++++++++++++++++
 tb/tb_dense_layer_sequencer.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dense_layer_sequencer.sv
// Dense 128x10 output layer sequencer: one shared MAC, bias add, scored stream out.
// Optional running argmax over the streamed scores when DENSE_ARGMAX_EN is defined.
module dense_layer_sequencer #(
  parameter int N_IN   = 128,
  parameter int N_OUT  = 10,
  parameter int FEAT_W = 8,
  parameter int W_W    = 6,
  parameter int ACC_W  = 21
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  output logic                     busy,
  output logic                     done,
  output logic [6:0]               feat_addr,
  input  logic signed [FEAT_W-1:0] feat_data,
  output logic [10:0]              w_addr,
  input  logic signed [W_W-1:0]    w_data,
  output logic [3:0]               b_addr,
  input  logic signed [W_W-1:0]    b_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [3:0]               out_idx,
  output logic signed [ACC_W-1:0]  out_data
`ifdef DENSE_ARGMAX_EN
  ,
  output logic                     class_valid,
  output logic [3:0]               class_id
`endif
);

  localparam int PW = FEAT_W + W_W;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_MAC  = 3'd1;
  localparam logic [2:0] S_BIAS = 3'd2;
  localparam logic [2:0] S_EMIT = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  localparam logic [7:0] LP_LAST  = 8'(N_IN);
  localparam logic [7:0] LP_ALAST = 8'(N_IN - 1);
  localparam logic [3:0] LP_NLAST = 4'(N_OUT - 1);

  logic [2:0]              r_state;
  logic [3:0]              r_n;
  logic [7:0]              r_i;
  logic [6:0]              r_feat_addr;
  logic [10:0]             r_w_addr;
  logic [3:0]              r_b_addr;
  logic signed [ACC_W-1:0] r_acc;
  logic signed [ACC_W-1:0] r_result;

  logic signed [PW-1:0]    w_f_ext;
  logic signed [PW-1:0]    w_w_ext;
  logic signed [PW-1:0]    w_prod;
  logic signed [ACC_W-1:0] w_prod_ext;
  logic signed [ACC_W-1:0] w_bias_ext;
  logic                    w_accept;

  // Full-precision product: operands widened first so nothing is truncated
  assign w_f_ext    = {{(PW-FEAT_W){feat_data[FEAT_W-1]}}, feat_data};
  assign w_w_ext    = {{(PW-W_W){w_data[W_W-1]}}, w_data};
  assign w_prod     = w_f_ext * w_w_ext;
  assign w_prod_ext = {{(ACC_W-PW){w_prod[PW-1]}}, w_prod};
  assign w_bias_ext = {{(ACC_W-W_W){b_data[W_W-1]}}, b_data};
  assign w_accept   = (r_state == S_EMIT) && out_ready;

  assign busy      = (r_state != S_IDLE);
  assign done      = (r_state == S_DONE);
  assign out_valid = (r_state == S_EMIT);
  assign out_idx   = r_n;
  assign out_data  = r_result;
  assign feat_addr = r_feat_addr;
  assign w_addr    = r_w_addr;
  assign b_addr    = r_b_addr;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_n         <= '0;
      r_i         <= '0;
      r_feat_addr <= '0;
      r_w_addr    <= '0;
      r_b_addr    <= '0;
      r_acc       <= '0;
      r_result    <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state     <= S_MAC;
            r_n         <= '0;
            r_i         <= '0;
            r_feat_addr <= '0;
            r_w_addr    <= '0;
            r_b_addr    <= '0;
          end
        end
        S_MAC: begin
          // Cycle 0 has no returned data yet, so it only clears
          r_acc <= (r_i == 8'd0) ? '0 : r_acc + w_prod_ext;
          if (r_i < LP_ALAST) begin
            r_feat_addr <= r_feat_addr + 7'd1;
            r_w_addr    <= r_w_addr + 11'd1;
          end
          if (r_i == LP_LAST) r_state <= S_BIAS;
          else r_i <= r_i + 8'd1;
        end
        S_BIAS: begin
          r_result <= r_acc + w_bias_ext;
          r_state  <= S_EMIT;
        end
        S_EMIT: begin
          if (out_ready) begin
            if (r_n == LP_NLAST) begin
              r_state <= S_DONE;
            end else begin
              // Next neuron's base row follows the last issued weight address
              r_n         <= r_n + 4'd1;
              r_i         <= '0;
              r_feat_addr <= '0;
              r_w_addr    <= r_w_addr + 11'd1;
              r_b_addr    <= r_n + 4'd1;
              r_state     <= S_MAC;
            end
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

`ifdef DENSE_ARGMAX_EN
  logic signed [ACC_W-1:0] r_max;
  logic [3:0]              r_cls;
  logic                    r_cls_valid;

  assign class_valid = r_cls_valid;
  assign class_id    = r_cls;

  // Index 0 seeds the max; strict compare keeps the lower index on ties
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_max       <= '0;
      r_cls       <= '0;
      r_cls_valid <= 1'b0;
    end else if (r_state == S_IDLE && start) begin
      r_max       <= '0;
      r_cls       <= '0;
      r_cls_valid <= 1'b0;
    end else if (w_accept) begin
      if (r_n == 4'd0 || r_result > r_max) begin
        r_max <= r_result;
        r_cls <= r_n;
      end
      if (r_n == LP_NLAST) r_cls_valid <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_dense_layer_sequencer.sv
// Directed bench for dense_layer_sequencer: vector table of whole inferences
// plus hand sequences for reset state and mid-inference reset.
module tb_dense_layer_sequencer;

  logic               clk = 1'b0;
  logic               reset;
  logic               start;
  logic               busy;
  logic               done;
  logic [6:0]         feat_addr;
  logic signed [7:0]  feat_data;
  logic [10:0]        w_addr;
  logic signed [5:0]  w_data;
  logic [3:0]         b_addr;
  logic signed [5:0]  b_data;
  logic               out_valid;
  logic               out_ready;
  logic [3:0]         out_idx;
  logic signed [20:0] out_data;
`ifdef DENSE_ARGMAX_EN
  logic               class_valid;
  logic [3:0]         class_id;
`endif

  dense_layer_sequencer dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .busy       (busy),
    .done       (done),
    .feat_addr  (feat_addr),
    .feat_data  (feat_data),
    .w_addr     (w_addr),
    .w_data     (w_data),
    .b_addr     (b_addr),
    .b_data     (b_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_idx    (out_idx),
    .out_data   (out_data)
`ifdef DENSE_ARGMAX_EN
    ,
    .class_valid(class_valid),
    .class_id   (class_id)
`endif
  );

  always #5 clk = ~clk;

  logic signed [7:0] fmem [128];
  logic signed [5:0] wrom [1280];
  logic signed [5:0] brom [10];

  always @(posedge clk) begin
    feat_data <= fmem[feat_addr];
    w_data    <= wrom[w_addr];
    b_data    <= brom[b_addr];
  end

  int errors = 0;
  int checks = 0;

  int bdef [10] = '{-1, -2, 0, -1, -1, -1, -1, -1, -1, 1};
  int btie [10] = '{-5, 0, 3, -1, 2, -4, 1, 3, 0, -2};

  typedef struct {
    int fm;
    int wm;
    int bm;
    int use_model;
    int stall_n;
    int stall_len;
    int exp_done;
    int exp_cls;
  } vec_t;

  localparam int NV = 6;
  vec_t vt [NV];
  int   exp_sc [NV][10];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic load(input int fm, input int wm, input int bm);
    int v;
    for (int k = 0; k < 128; k++) begin
      case (fm)
        0:       v = 0;
        1:       v = 1;
        2:       v = (k % 17) - 8;
        default: v = -128;
      endcase
      fmem[k] = 8'(v);
    end
    for (int a = 0; a < 1280; a++) begin
      case (wm)
        0:       v = ((a * 37 + 11) % 64) - 32;
        1:       v = -32;
        default: v = 31;
      endcase
      wrom[a] = 6'(v);
    end
    for (int n = 0; n < 10; n++) begin
      case (bm)
        0:       v = bdef[n];
        1:       v = btie[n];
        default: v = 0;
      endcase
      brom[n] = 6'(v);
    end
  endtask

  task automatic model(input int vi);
    int s;
    int best;
    for (int n = 0; n < 10; n++) begin
      s = int'(brom[n]);
      for (int k = 0; k < 128; k++)
        s += int'(fmem[k]) * int'(wrom[n * 128 + k]);
      exp_sc[vi][n] = s;
    end
    best = 0;
    for (int n = 1; n < 10; n++)
      if (exp_sc[vi][n] > exp_sc[vi][best]) best = n;
    vt[vi].exp_cls = best;
  endtask

  task automatic run(input int vi, input int spur);
    int c;
    int k;
    int st_left;
    int bad;
    int stab_bad;
    int got;
    bit fin;
    logic signed [20:0] hold;
    hold = '0;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    c = 1; k = 0; bad = 0; stab_bad = 0; fin = 1'b0;
    st_left = vt[vi].stall_len;
    chk($sformatf("v%0d_busy_t1", vi), int'(busy), 1);
    chk($sformatf("v%0d_faddr_t1", vi), int'(feat_addr), 0);
    while (!fin && c < 3000) begin
      if (c >= 1 && c <= 128 && int'(w_addr) != c - 1) bad++;
      if (c >= 132 && c <= 259 && int'(w_addr) != 128 + c - 132) bad++;
      start = (c == spur);
      if (done) begin
        chk($sformatf("v%0d_done_cycle", vi), c, vt[vi].exp_done);
        chk($sformatf("v%0d_busy_done", vi), int'(busy), 1);
`ifdef DENSE_ARGMAX_EN
        chk($sformatf("v%0d_class_valid", vi), int'(class_valid), 1);
        chk($sformatf("v%0d_class_id", vi), int'(class_id), vt[vi].exp_cls);
`endif
        fin = 1'b1;
      end else if (out_valid) begin
        if (int'(out_idx) == vt[vi].stall_n && st_left > 0) begin
          if (st_left == vt[vi].stall_len) hold = out_data;
          else if (out_data !== hold) stab_bad++;
          out_ready = 1'b0;
          st_left--;
        end else begin
          if (vt[vi].stall_len > 0 && int'(out_idx) == vt[vi].stall_n &&
              out_data !== hold) stab_bad++;
          out_ready = 1'b1;
          got = $signed(out_data);
          chk($sformatf("v%0d_idx%0d", vi, k), int'(out_idx), k);
          if (k < 10)
            chk($sformatf("v%0d_score%0d", vi, k), got, exp_sc[vi][k]);
          k++;
        end
      end else begin
        out_ready = 1'b1;
      end
      if (!fin) begin
        @(posedge clk); #1;
        c++;
      end
    end
    start = 1'b0;
    out_ready = 1'b1;
    if (!fin) begin
      errors++;
      checks++;
      $display("FAIL v%0d_timeout: no done after %0d cycles", vi, c);
    end
    chk($sformatf("v%0d_score_count", vi), k, 10);
    chk($sformatf("v%0d_waddr_steps_bad", vi), bad, 0);
    if (vt[vi].stall_len > 0)
      chk($sformatf("v%0d_stall_stability_bad", vi), stab_bad, 0);
    @(posedge clk); #1;
    chk($sformatf("v%0d_idle_busy", vi), int'(busy), 0);
    chk($sformatf("v%0d_idle_done", vi), int'(done), 0);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_done"}, int'(done), 0);
    chk({tag, "_out_valid"}, int'(out_valid), 0);
    chk({tag, "_feat_addr"}, int'(feat_addr), 0);
    chk({tag, "_w_addr"}, int'(w_addr), 0);
    chk({tag, "_b_addr"}, int'(b_addr), 0);
    chk({tag, "_out_idx"}, int'(out_idx), 0);
    chk({tag, "_out_data"}, int'($signed(out_data)), 0);
`ifdef DENSE_ARGMAX_EN
    chk({tag, "_class_valid"}, int'(class_valid), 0);
    chk({tag, "_class_id"}, int'(class_id), 0);
`endif
  endtask

  initial begin
    // fm, wm, bm, model, stall_n, stall_len, done cycle, class
    vt[0] = '{0, 0, 0, 0, -1, 0, 1311, 9};
    vt[1] = '{1, 0, 0, 1, -1, 0, 1311, 0};
    vt[2] = '{2, 0, 0, 1,  3, 5, 1316, 0};
    vt[3] = '{3, 1, 2, 0, -1, 0, 1311, 0};
    vt[4] = '{0, 0, 1, 0, -1, 0, 1311, 2};
    vt[5] = '{3, 2, 0, 0, -1, 0, 1311, 9};
    for (int n = 0; n < 10; n++) begin
      exp_sc[0][n] = bdef[n];
      exp_sc[3][n] = 524288;
      exp_sc[4][n] = btie[n];
      exp_sc[5][n] = -507904 + bdef[n];
    end

    reset = 1'b1;
    start = 1'b0;
    out_ready = 1'b1;
    load(0, 0, 0);
    repeat (2) @(posedge clk);
    #1 chk_zero("reset");
    reset = 1'b0;

    for (int vi = 0; vi < NV; vi++) begin
      load(vt[vi].fm, vt[vi].wm, vt[vi].bm);
      if (vt[vi].use_model != 0) model(vi);
      run(vi, 0);
    end

    // Mid-inference reset during neuron 4, then a clean rerun with a stray start
    load(vt[1].fm, vt[1].wm, vt[1].bm);
    model(1);
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (574) @(posedge clk);
    #1 chk("midrst_b_addr_n4", int'(b_addr), 4);
    chk("midrst_busy_before", int'(busy), 1);
    #2 reset = 1'b1;
    #1 chk_zero("midrst");
    @(posedge clk); #1 reset = 1'b0;
    chk("midrst_no_done", int'(done), 0);
    run(1, 600);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
